up_count_checker: RTL and testbench

//   Sequence checker for the up_counter count bus. It samples a WIDTH-bit count stream and

---
 rtl/ucc_pkg.sv | 21 ++
 rtl/sat_counter.sv | 38 +++
 rtl/up_count_checker.sv | 133 +++++++++++++
 tb/tb_up_count_checker.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ucc_pkg.sv
// Shared types and helpers for the up-counter sequence checker.
package ucc_pkg;

   // Checker tracking state: hunting for a first sample, confirming, tracking.
   typedef enum logic [1:0] {
      UNSYNC  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } ucc_state_e;

   // Increment v, holding at the all-ones value of a w-bit field (w < 32).
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] max_v;
      max_v = (32'd1 << w) - 32'd1;
      if (v >= max_v) begin
         return max_v;
      end
      return v + 32'd1;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear and async active-low reset.
module sat_counter
   import ucc_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   // Next count: clear wins, otherwise bump and stick at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/up_count_checker.sv
// Sequence checker for an up-counter bus: locks onto a +1 (mod 2^WIDTH) stream,
// pulses on breaks while locked, and keeps saturating error and wrap statistics.
module up_count_checker
   import ucc_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int LOCK_CNT = 3,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid,
   input  logic [WIDTH-1:0] count_in,
   input  logic             clr,
   output logic             locked,
   output logic             mismatch,
   output logic             err_sticky,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] wrap_count,
   output logic [WIDTH-1:0] expected
);

   localparam int GOOD_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

   ucc_state_e        state_d, state_q;
   logic [GOOD_W-1:0] good_d, good_q;
   logic [GOOD_W-1:0] good_nxt;
   logic [WIDTH-1:0]  expected_d, expected_q;
   logic              locked_d, locked_q;
   logic              mismatch_d, mismatch_q;
   logic              err_sticky_d, err_sticky_q;
   logic              match;
   logic              err_inc;
   logic              wrap_inc;

   assign match    = (count_in == expected_q);
   assign good_nxt = good_q + GOOD_W'(1);

   // Next-state logic. A matching 0 implies the previous sample was all-ones,
   // because expected is always last sample + 1, so wrap detection needs no
   // extra history register.
   always_comb begin
      state_d      = state_q;
      good_d       = good_q;
      expected_d   = expected_q;
      mismatch_d   = 1'b0;
      err_sticky_d = err_sticky_q;
      err_inc      = 1'b0;
      wrap_inc     = 1'b0;
      if (clr) begin
         state_d      = UNSYNC;
         good_d       = '0;
         expected_d   = '0;
         err_sticky_d = 1'b0;
      end else if (valid) begin
         expected_d = count_in + WIDTH'(1);
         case (state_q)
            UNSYNC: begin
               good_d  = '0;
               state_d = ACQUIRE;
            end
            ACQUIRE: begin
               if (match) begin
                  good_d   = good_nxt;
                  wrap_inc = (count_in == '0);
                  if (good_nxt == GOOD_W'(LOCK_CNT)) begin
                     state_d = LOCKED;
                  end
               end else begin
                  good_d = '0;
               end
            end
            LOCKED: begin
               if (match) begin
                  wrap_inc = (count_in == '0);
               end else begin
                  mismatch_d   = 1'b1;
                  err_inc      = 1'b1;
                  err_sticky_d = 1'b1;
                  good_d       = '0;
                  state_d      = ACQUIRE;
               end
            end
            default: begin
               good_d  = '0;
               state_d = UNSYNC;
            end
         endcase
      end
      locked_d = (state_d == LOCKED);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= UNSYNC;
         good_q       <= '0;
         expected_q   <= '0;
         locked_q     <= 1'b0;
         mismatch_q   <= 1'b0;
         err_sticky_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         good_q       <= good_d;
         expected_q   <= expected_d;
         locked_q     <= locked_d;
         mismatch_q   <= mismatch_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (err_inc),
      .clr   (clr),
      .count (err_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_wrap_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (wrap_inc),
      .clr   (clr),
      .count (wrap_count)
   );

   assign locked     = locked_q;
   assign mismatch   = mismatch_q;
   assign err_sticky = err_sticky_q;
   assign expected   = expected_q;

endmodule

// File: tb/tb_up_count_checker.sv
// Directed bench for up_count_checker: a default instance plus a CNT_W=2
// instance sharing the same stimulus to exercise counter saturation.
module tb_up_count_checker;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       valid = 1'b0;
   logic [3:0] count_in = '0;
   logic       clr = 1'b0;

   logic       locked, mismatch, err_sticky;
   logic [7:0] err_count, wrap_count;
   logic [3:0] expected;

   logic       locked2, mismatch2, err_sticky2;
   logic [1:0] err_count2, wrap_count2;
   logic [3:0] expected2;

   int total = 0;
   int bad = 0;
   int pulses = 0;
   int pulses2 = 0;

   always #5 clk = ~clk;

   up_count_checker #(.WIDTH(4), .LOCK_CNT(3), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .valid(valid), .count_in(count_in), .clr(clr),
      .locked(locked), .mismatch(mismatch), .err_sticky(err_sticky),
      .err_count(err_count), .wrap_count(wrap_count), .expected(expected)
   );

   up_count_checker #(.WIDTH(4), .LOCK_CNT(3), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .valid(valid), .count_in(count_in), .clr(clr),
      .locked(locked2), .mismatch(mismatch2), .err_sticky(err_sticky2),
      .err_count(err_count2), .wrap_count(wrap_count2), .expected(expected2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
      end
   endtask

   // Called at a falling edge: drive inputs, pass one rising edge, land on the
   // next falling edge where outputs reflect this cycle's sample.
   task automatic step(input logic v, input logic [3:0] c, input logic cl);
      valid    = v;
      count_in = c;
      clr      = cl;
      @(negedge clk);
      if (mismatch === 1'b1) pulses++;
      if (mismatch2 === 1'b1) pulses2++;
      valid = 1'b0;
      clr   = 1'b0;
   endtask

   task automatic run(input int first, input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b1, 4'((first + i) % 16), 1'b0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_locked", locked, 0);
      check("rst_mismatch", mismatch, 0);
      check("rst_sticky", err_sticky, 0);
      check("rst_err", err_count, 0);
      check("rst_wrap", wrap_count, 0);
      check("rst_expected", expected, 0);
      reset = 1'b1;
      @(negedge clk);

      // Lock onto 0..5.
      run(0, 3);
      check("t1_not_locked_at2", locked, 0);
      run(3, 1);
      check("t1_locked_at3", locked, 1);
      run(4, 2);
      check("t1_locked", locked, 1);
      check("t1_err", err_count, 0);
      check("t1_expected", expected, 6);

      // Run up through the wrap 13,14,15,0,1.
      run(6, 12);
      check("t2_wrap", wrap_count, 1);
      check("t2_pulses", pulses, 0);
      check("t2_expected", expected, 2);
      check("t2_locked", locked, 1);

      // Break: 2..7 then 9 instead of 8, then 10,11,12.
      run(2, 6);
      run(9, 1);
      check("t3_mismatch", mismatch, 1);
      check("t3_err", err_count, 1);
      check("t3_sticky", err_sticky, 1);
      check("t3_unlocked", locked, 0);
      check("t3_expected", expected, 10);
      run(10, 1);
      check("t3_pulse_width", mismatch, 0);
      run(11, 1);
      check("t3_still_unlocked", locked, 0);
      run(12, 1);
      check("t3_relocked", locked, 1);
      check("t3_pulses", pulses, 1);

      // Gap of idle cycles between 13 and 14.
      run(13, 1);
      repeat (4) step(1'b0, 4'd3, 1'b0);
      check("t4_expected_hold", expected, 14);
      run(14, 1);
      check("t4_pulses", pulses, 1);
      check("t4_err", err_count, 1);
      check("t4_wrap", wrap_count, 1);
      check("t4_locked", locked, 1);
      check("t4_expected", expected, 15);

      // clr together with a valid sample of 8 while locked.
      step(1'b1, 4'd8, 1'b1);
      check("t5_locked", locked, 0);
      check("t5_sticky", err_sticky, 0);
      check("t5_err", err_count, 0);
      check("t5_wrap", wrap_count, 0);
      check("t5_expected", expected, 0);
      check("t5_mismatch", mismatch, 0);
      pulses  = 0;
      pulses2 = 0;

      // Five forced breaks, relocking between each: 0..3, 8..11, 0..3, 8..11, 0..3, 8.
      run(0, 4);
      check("t6_locked", locked, 1);
      for (int k = 0; k < 2; k++) begin
         run(8, 4);
         run(0, 4);
      end
      run(8, 1);
      check("t6_err", err_count, 5);
      check("t6_err_sat", err_count2, 3);
      check("t6_pulses", pulses, 5);
      check("t6_pulses_sat", pulses2, 5);
      check("t6_sticky_sat", err_sticky2, 1);
      run(9, 1);

      // Asynchronous reset between edges.
      #2;
      reset = 1'b0;
      #1;
      check("t6_rst_locked", locked, 0);
      check("t6_rst_sticky", err_sticky, 0);
      check("t6_rst_err", err_count, 0);
      check("t6_rst_err_sat", err_count2, 0);
      check("t6_rst_expected", expected, 0);
      check("t6_rst_mismatch", mismatch, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // First sample after reset is taken as from UNSYNC.
      run(7, 1);
      check("t7_expected", expected, 8);
      check("t7_mismatch", mismatch, 0);
      check("t7_locked", locked, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
